// File: rtl/btn_event_ctrl.sv
// Multi-channel button front end: 2-FF synchroniser, debounce, press/release pulses,
// and optional per-channel auto-repeat with long-press indication.
module btn_event_ctrl #(
    parameter int               N_BTN           = 2,
    parameter int               ACTIVE_LOW      = 1,
    parameter int               MIN_PULSE_WIDTH = 25000,
    parameter int               CNT_W           = 24,
    parameter int               REPEAT_DELAY    = 12500000,
    parameter int               REPEAT_RATE     = 2500000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = {N_BTN{1'b1}}
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_btn,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_long,
    output logic             o_event
);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_TERM  = CNT_W'(MIN_PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] RD_TERM  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_TERM  = CNT_W'(REPEAT_RATE - 1);
    localparam logic             IDLE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    logic [N_BTN-1:0] press_nxt_s;
    logic [N_BTN-1:0] release_nxt_s;
    logic             event_r;

    genvar k;
    generate
        for (k = 0; k < N_BTN; k++) begin : g_ch
            logic             sync1_r;
            logic             sync2_r;
            logic             raw_s;
            logic [CNT_W-1:0] dcnt_r;
            logic [CNT_W-1:0] dcnt_nxt_s;
            logic             toggle_s;
            logic             btn_r;
            logic             press_evt_s;
            logic             release_evt_s;
            rpt_state_t       state_r;
            rpt_state_t       state_nxt_s;
            logic [CNT_W-1:0] rcnt_r;
            logic [CNT_W-1:0] rcnt_nxt_s;
            logic             long_r;
            logic             long_nxt_s;
            logic             tick_s;
            logic             press_r;
            logic             release_r;

            // Synchroniser, preloaded with the not-pressed pin level.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    sync1_r <= IDLE_LVL;
                    sync2_r <= IDLE_LVL;
                end else begin
                    sync1_r <= i_btn[k];
                    sync2_r <= sync1_r;
                end
            end

            assign raw_s = (ACTIVE_LOW != 0) ? ~sync2_r : sync2_r;

            // Debounce: count consecutive disagreeing cycles, toggle at the window end.
            always_comb begin
                toggle_s   = 1'b0;
                dcnt_nxt_s = CNT_ZERO;
                if (raw_s == btn_r) begin
                    dcnt_nxt_s = CNT_ZERO;
                end else if (dcnt_r == DB_TERM) begin
                    toggle_s   = 1'b1;
                    dcnt_nxt_s = CNT_ZERO;
                end else begin
                    dcnt_nxt_s = dcnt_r + CNT_ONE;
                end
            end

            assign press_evt_s   = toggle_s & ~btn_r;
            assign release_evt_s = toggle_s & btn_r;

            // Repeat FSM next state; a release always wins over a coincident repeat tick.
            always_comb begin
                state_nxt_s = state_r;
                rcnt_nxt_s  = rcnt_r;
                long_nxt_s  = long_r;
                tick_s      = 1'b0;
                if (!REPEAT_MASK[k]) begin
                    state_nxt_s = ST_IDLE;
                    rcnt_nxt_s  = CNT_ZERO;
                    long_nxt_s  = 1'b0;
                end else if (release_evt_s) begin
                    state_nxt_s = ST_IDLE;
                    rcnt_nxt_s  = CNT_ZERO;
                    long_nxt_s  = 1'b0;
                end else begin
                    case (state_r)
                        ST_IDLE: begin
                            rcnt_nxt_s = CNT_ZERO;
                            if (press_evt_s) begin
                                state_nxt_s = ST_HOLD;
                            end else begin
                                state_nxt_s = ST_IDLE;
                            end
                        end
                        ST_HOLD: begin
                            if (rcnt_r == RD_TERM) begin
                                tick_s      = 1'b1;
                                long_nxt_s  = 1'b1;
                                rcnt_nxt_s  = CNT_ZERO;
                                state_nxt_s = ST_REPEAT;
                            end else begin
                                rcnt_nxt_s = rcnt_r + CNT_ONE;
                            end
                        end
                        ST_REPEAT: begin
                            if (rcnt_r == RR_TERM) begin
                                tick_s     = 1'b1;
                                rcnt_nxt_s = CNT_ZERO;
                            end else begin
                                rcnt_nxt_s = rcnt_r + CNT_ONE;
                            end
                        end
                        default: begin
                            state_nxt_s = ST_IDLE;
                            rcnt_nxt_s  = CNT_ZERO;
                            long_nxt_s  = 1'b0;
                        end
                    endcase
                end
            end

            assign press_nxt_s[k]   = press_evt_s | tick_s;
            assign release_nxt_s[k] = release_evt_s;

            // Channel state and registered outputs.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    dcnt_r    <= CNT_ZERO;
                    btn_r     <= 1'b0;
                    state_r   <= ST_IDLE;
                    rcnt_r    <= CNT_ZERO;
                    long_r    <= 1'b0;
                    press_r   <= 1'b0;
                    release_r <= 1'b0;
                end else begin
                    dcnt_r    <= dcnt_nxt_s;
                    btn_r     <= btn_r ^ toggle_s;
                    state_r   <= state_nxt_s;
                    rcnt_r    <= rcnt_nxt_s;
                    long_r    <= long_nxt_s;
                    press_r   <= press_nxt_s[k];
                    release_r <= release_nxt_s[k];
                end
            end

            assign o_btn[k]     = btn_r;
            assign o_press[k]   = press_r;
            assign o_release[k] = release_r;
            assign o_long[k]    = long_r;
        end
    endgenerate

    // Summary event flag, registered alongside the per-channel pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            event_r <= 1'b0;
        end else begin
            event_r <= |(press_nxt_s | release_nxt_s);
        end
    end

    assign o_event = event_r;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: directed scenarios plus random pin activity, checked every
// cycle against a window/hold-time reference model.
module tb_btn_event_ctrl;

    localparam int         N    = 2;
    localparam int         AL   = 1;
    localparam int         MPW  = 4;
    localparam int         RD   = 10;
    localparam int         RR   = 3;
    localparam logic [1:0] MASK = 2'b01;
    localparam logic [1:0] IDLE_PINS = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_pins;
    logic [N-1:0] d_btn, d_press, d_release, d_long;
    logic         d_event;

    btn_event_ctrl #(
        .N_BTN(N), .ACTIVE_LOW(AL), .MIN_PULSE_WIDTH(MPW), .CNT_W(8),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_MASK(MASK)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_btn(btn_pins),
        .o_btn(d_btn), .o_press(d_press), .o_release(d_release),
        .o_long(d_long), .o_event(d_event)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_rep    = 0;

    // reference model state (values expected after the most recent edge)
    logic [N-1:0] e_btn, e_press, e_rel, e_long;
    logic         e_ev;
    logic         hist [0:N-1][0:MPW];   // pressed-level samples, [MPW] = newest
    int           pstart [0:N-1];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Predict the outputs after the next edge, given reset and pins at that edge.
    task automatic model_step(input logic r, input logic [N-1:0] pins);
        logic s, all_diff;
        int h;
        cyc++;
        if (r) begin
            e_btn = '0; e_press = '0; e_rel = '0; e_long = '0;
            for (int k = 0; k < N; k++)
                for (int j = 0; j <= MPW; j++) hist[k][j] = 1'b0;
        end else begin
            e_press = '0; e_rel = '0;
            for (int k = 0; k < N; k++) begin
                s = (AL != 0) ? ~pins[k] : pins[k];
                all_diff = 1'b1;
                for (int j = 0; j < MPW; j++)
                    if (hist[k][j] == e_btn[k]) all_diff = 1'b0;
                if (all_diff) begin
                    if (!e_btn[k]) begin
                        e_press[k] = 1'b1; e_btn[k] = 1'b1; pstart[k] = cyc;
                    end else begin
                        e_rel[k] = 1'b1; e_btn[k] = 1'b0; e_long[k] = 1'b0;
                    end
                end else if (e_btn[k] && MASK[k]) begin
                    h = cyc - pstart[k];
                    if (h >= RD && ((h - RD) % RR) == 0) begin
                        e_press[k] = 1'b1;
                        n_rep++;
                    end
                    if (h >= RD) e_long[k] = 1'b1;
                end
                for (int j = 0; j < MPW; j++) hist[k][j] = hist[k][j+1];
                hist[k][MPW] = s;
            end
        end
        e_ev = |(e_press | e_rel);
    endtask

    // One cycle: compare current outputs, then drive and predict the next edge.
    task automatic cycle(input logic r, input logic [N-1:0] pins);
        @(negedge clk);
        chk_eq("o_btn", 32'(d_btn), 32'(e_btn));
        chk_eq("o_press", 32'(d_press), 32'(e_press));
        chk_eq("o_release", 32'(d_release), 32'(e_rel));
        chk_eq("o_long", 32'(d_long), 32'(e_long));
        chk_eq("o_event", 32'(d_event), 32'(e_ev));
        rst = r;
        btn_pins = pins;
        model_step(r, pins);
    endtask

    task automatic hold(input logic r, input logic [N-1:0] pins, input int n);
        for (int i = 0; i < n; i++) cycle(r, pins);
    endtask

    int         rem [0:N-1];
    logic [N-1:0] lv;
    int         sel;
    logic       rr;

    initial begin
        for (int k = 0; k < N; k++) pstart[k] = 0;
        rst = 1'b1;
        btn_pins = IDLE_PINS;
        model_step(1'b1, IDLE_PINS);
        hold(1'b1, IDLE_PINS, 3);
        hold(1'b0, IDLE_PINS, 6);
        // both channels pressed together, ch0 auto-repeats, ch1 does not
        hold(1'b0, 2'b00, 30);
        hold(1'b0, IDLE_PINS, 15);
        // ch0 release lands on the second repeat tick
        hold(1'b0, 2'b10, 13);
        hold(1'b0, IDLE_PINS, 15);
        // reset while ch0 is repeating, pin still held
        hold(1'b0, 2'b10, 25);
        hold(1'b1, 2'b10, 1);
        hold(1'b0, 2'b10, 30);
        hold(1'b0, IDLE_PINS, 15);
        // glitches shorter than the debounce window
        hold(1'b0, 2'b10, 1); hold(1'b0, IDLE_PINS, 5);
        hold(1'b0, 2'b10, 2); hold(1'b0, IDLE_PINS, 5);
        hold(1'b0, 2'b10, 3); hold(1'b0, IDLE_PINS, 5);
        // random activity
        lv = IDLE_PINS;
        for (int k = 0; k < N; k++) rem[k] = 0;
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < N; k++) begin
                if (rem[k] == 0) begin
                    lv[k] = ~lv[k];
                    sel = int'($urandom_range(0, 9));
                    if (sel < 3)      rem[k] = int'($urandom_range(1, 4));
                    else if (sel < 6) rem[k] = int'($urandom_range(5, 12));
                    else              rem[k] = int'($urandom_range(13, 45));
                end
                rem[k]--;
            end
            rr = ($urandom_range(0, 399) == 0);
            cycle(rr, lv);
        end
        hold(1'b0, IDLE_PINS, 20);
        chk_eq("repeats_seen", 32'(n_rep > 20), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
